// File: rtl/uart_tx_frame.sv
// UART transmit framer: latches a word and its framing options on accept, then
// sends start, LSB-first data, optional parity and one or two stop bits at one bit per clk.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic [1:0]            par_mode,
    input  logic                  stop2,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  par_bit,
    output logic                  frame_done,
    output logic [2:0]            state_dbg
);

    // Handshake: data_valid is sampled only in IDLE; a word is taken at the rising
    // edge where state is IDLE and data_valid is high, and busy rises on that same
    // edge. data_valid while busy is dropped, so upstream holds it until busy falls.

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pen_q, pen_d;
    logic                  s2_q, s2_d;
    logic                  par_d, tx_d, busy_d, done_d;
    logic                  par_calc;

    always_comb begin
        unique case (par_mode)
            2'b00:   par_calc = ^p_data;
            2'b01:   par_calc = ~(^p_data);
            2'b10:   par_calc = 1'b1;
            default: par_calc = 1'b0;
        endcase
    end

    // tx_out, busy and frame_done are registered from the state being entered,
    // so each output bit lines up with the cycle of its state.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        pen_d   = pen_q;
        s2_d    = s2_q;
        par_d   = par_bit;
        tx_d    = 1'b1;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (data_valid) begin
                    state_d = S_START;
                    shift_d = p_data;
                    pen_d   = par_en;
                    s2_d    = stop2;
                    par_d   = par_calc;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                state_d = S_DATA;
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
                cnt_d   = '0;
            end
            S_DATA: begin
                if (cnt_q == LAST_BIT) begin
                    if (pen_q) begin
                        state_d = S_PARITY;
                        tx_d    = par_bit;
                    end else begin
                        state_d = S_STOP1;
                        done_d  = ~s2_q;
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            S_PARITY: begin
                state_d = S_STOP1;
                done_d  = ~s2_q;
            end
            S_STOP1: begin
                if (s2_q) begin
                    state_d = S_STOP2;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_STOP2: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            pen_q      <= 1'b0;
            s2_q       <= 1'b0;
            par_bit    <= 1'b0;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            pen_q      <= pen_d;
            s2_q       <= s2_d;
            par_bit    <= par_d;
            tx_out     <= tx_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

    assign state_dbg = state_q;

endmodule
